// File: rtl/envelope_gen.sv
// envelope_gen: ADSR amplitude envelope placed after the wave generator.
//
// A 16-bit level accumulator is driven through attack/decay/sustain/release
// phases by a level-sensitive gate. The upper byte of the level is the envelope,
// and the incoming sample is scaled by it (one cycle of latency).
//
// Optional feature: define ENVGEN_PRESCALE_EN to add a free-running
// PRESCALE_BITS-bit counter; level updates then happen only when the counter is
// all-ones. Without the macro every cycle is an update cycle.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   gate          note on (1) / off (0), level-sensitive
//   attack_rate   added to level per update in attack
//   decay_rate    subtracted from level per update in decay
//   sustain_level sustain target (upper byte of level)
//   release_rate  subtracted from level per update in release
//   waveform      unsigned input sample
//   envelope      level[15:8]
//   audio         (waveform * envelope) >> 8, registered
//   state         0 idle, 1 attack, 2 decay, 3 sustain, 4 release
//   active        state != idle
module envelope_gen #(
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gate,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    input  logic [7:0] waveform,
    output logic [7:0] envelope,
    output logic [7:0] audio,
    output logic [2:0] state,
    output logic       active
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] level_q, level_d;
    logic [7:0]  audio_q;
    logic        update;

`ifdef ENVGEN_PRESCALE_EN
    localparam logic [PRESCALE_BITS-1:0] PreOne = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] pre_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PreOne;
        end
    end

    assign update = &pre_q;
`else
    logic unused_prescale_bits;
    assign unused_prescale_bits = ^PRESCALE_BITS;
    assign update = 1'b1;
`endif

    // 17-bit arithmetic so carry/borrow expose saturation and underflow.
    logic [16:0] attack_sum;
    logic [16:0] decay_diff;
    logic [15:0] sustain_floor;
    logic        attack_full;
    logic        decay_hits;
    logic        release_hits;

    assign attack_sum    = {1'b0, level_q} + {9'b0, attack_rate};
    assign decay_diff    = {1'b0, level_q} - {9'b0, decay_rate};
    assign sustain_floor = {sustain_level, 8'h00};
    assign attack_full   = (attack_sum >= 17'h0FFFF);
    assign decay_hits    = decay_diff[16] || (decay_diff[15:0] <= sustain_floor);
    assign release_hits  = (level_q <= {8'h00, release_rate});

    // Gate transitions take priority and freeze the level for that cycle.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            StIdle: begin
                if (gate) begin
                    state_d = StAttack;
                end
            end
            StAttack: begin
                if (!gate) begin
                    state_d = StRelease;
                end else if (update) begin
                    if (attack_full) begin
                        level_d = 16'hFFFF;
                        state_d = StDecay;
                    end else begin
                        level_d = attack_sum[15:0];
                    end
                end
            end
            StDecay: begin
                if (!gate) begin
                    state_d = StRelease;
                end else if (update) begin
                    if (decay_hits) begin
                        level_d = sustain_floor;
                        state_d = StSustain;
                    end else begin
                        level_d = decay_diff[15:0];
                    end
                end
            end
            StSustain: begin
                if (!gate) begin
                    state_d = StRelease;
                end else if (update) begin
                    level_d = sustain_floor;
                end
            end
            StRelease: begin
                if (gate) begin
                    state_d = StAttack;
                end else if (update) begin
                    if (release_hits) begin
                        level_d = 16'h0000;
                        state_d = StIdle;
                    end else begin
                        level_d = level_q - {8'h00, release_rate};
                    end
                end
            end
            default: begin
                state_d = StIdle;
                level_d = 16'h0000;
            end
        endcase
    end

    logic [15:0] product;
    assign product = {8'h00, waveform} * {8'h00, level_q[15:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            level_q <= 16'h0000;
            audio_q <= 8'h00;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            audio_q <= product[15:8];
        end
    end

    assign envelope = level_q[15:8];
    assign audio    = audio_q;
    assign state    = state_q;
    assign active   = (state_q != StIdle);

endmodule

// File: doc/envelope_gen.md
# envelope_gen

ADSR amplitude envelope stage placed directly downstream of the wave generator. It consumes the 8-bit unsigned waveform sample and a note gate, and runs an attack/decay/sustain/release state machine over a 16-bit level accumulator. It outputs the waveform scaled by the envelope, ready for the mixer/DAC stage.

## Interface
- PRESCALE_BITS, 8, width of the update prescaler; used only when ENVGEN_PRESCALE_EN is defined.
- Clock  in  1  system clock, all logic on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Gate  in  1  note on (1) / note off (0), level-sensitive.
- Attack  in  8  amount added to level per update in ATTACK.
- Decay  in  8  amount subtracted from level per update in DECAY.
- Sustain  in  8  sustain level (upper byte of level).
- Release  in  8  amount subtracted from level per update in RELEASE.
- Waveform  in  8  unsigned sample from the wave generator.
- Envelope  out  8  current envelope, level[15:8], registered.
- Audio  out  8  (Waveform × Envelope) >> 8, registered.
- State  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Active  out  1  State != IDLE.

## Operation
- Reset (async, Reset_n=0): State=IDLE, level=0x0000, Envelope=0x00, Audio=0x00, Active=0, prescaler=0.
- Level is 16 bits. Rates are zero-extended to 16 bits. All add/subtract operations saturate; the level never wraps.
- Gate-driven transitions are taken on any clock edge. The level is not updated in a gate-transition cycle.
  - Gate=1 in IDLE or RELEASE -> ATTACK. Retrigger keeps the current level; no reset to 0.
  - Gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE.
- Level updates occur only on update cycles: every cycle, or on prescaler ticks (see Configuration).
  - ATTACK: level += Attack. If the sum is ≥ 0xFFFF, level=0xFFFF and State -> DECAY in the same edge.
  - DECAY: if level − Decay ≤ {Sustain,8'h00} (including underflow), level={Sustain,8'h00} and State -> SUSTAIN. Otherwise level −= Decay.
  - SUSTAIN: level={Sustain,8'h00} on every update, so it tracks live Sustain changes.
  - RELEASE: if level ≤ Release, level=0 and State -> IDLE. Otherwise level −= Release.
  - IDLE: level held at 0.
- A rate of 0 holds the level indefinitely in that phase. This is legal and not an error.
- Simultaneous events: a gate transition has priority over a saturation/threshold transition in the same cycle. Example: Gate falls on the edge where ATTACK would saturate -> State=RELEASE, level unchanged.
- Rate or Sustain inputs may change at any time and take effect on the next update.

## Timing
- Envelope is level[15:8] registered, so it reflects the state after each edge.
- Audio latency is 1 cycle. Audio at edge n+1 = (Waveform@n × Envelope@n)[15:8].
- Full-scale product: 0xFF × 0xFF -> 0xFE. No rounding is applied.
- When Reset_n is asserted mid-envelope, all outputs clear immediately (asynchronously). After release, the first edge behaves as IDLE.

## Configuration
- ENVGEN_PRESCALE_EN defined:
  - A free-running PRESCALE_BITS-bit counter is included.
  - Update cycles are only those where the counter equals all-ones, i.e. one update every 2^PRESCALE_BITS cycles.
  - Gate transitions remain per-cycle.
- ENVGEN_PRESCALE_EN undefined:
  - No prescaler logic is built.
  - Every cycle is an update cycle.

## Test plan
All scenarios run with ENVGEN_PRESCALE_EN undefined unless stated.
- Reset: Reset_n=0 mid-ATTACK -> Envelope=0x00, Audio=0x00, State=0, Active=0 without waiting for a clock edge.
- Attack:
  - Setup: Gate 0->1, Attack=0x80.
  - Required: State=1 on the next edge.
  - Required: after 512 updates, level=0xFFFF, Envelope=0xFF, State=2.
- Decay:
  - Setup: continue from the attack scenario with Decay=0xFF, Sustain=0x80.
  - Required: after 129 updates, level=0x8000, Envelope=0x80, State=3.
- Scaling: in SUSTAIN at 0x80, Waveform=0xC8 -> Audio=0x64 one cycle later. With Waveform=0xFF and Envelope=0xFF, Audio=0xFE.
- Release and retrigger:
  - Setup: Gate=0 in SUSTAIN with Release=0x80.
  - Required: State=4, then after 256 updates Envelope=0x00, State=0.
  - Retrigger: raise Gate when Envelope=0x40 -> State=1 and the ramp continues from 0x40, not 0.
- Prescaler: with ENVGEN_PRESCALE_EN and PRESCALE_BITS=4, the attack scenario reaches Envelope=0xFF after 512×16 cycles (±16). Gate falling mid-attack still gives State=4 on the next edge.
